// File: rtl/bus_arb_mux.sv
// N-input arbitrating bus multiplexer: round-robin or fixed-priority grant,
// one registered output stage, valid/ready handshakes on every channel.
module bus_arb_mux #(
    parameter  int WIDTH = 64,
    parameter  int N     = 4,
    parameter  int MODE  = 0,
    localparam int SELW  = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0][WIDTH-1:0]   in_data,
    input  logic [N-1:0]              in_valid,
    output logic [N-1:0]              in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SELW-1:0]           out_sel
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SELW-1:0]  r_out_sel;
    logic [SELW-1:0]  r_ptr;

    logic             w_can_load;
    logic             w_gnt_any;
    logic [SELW-1:0]  w_gnt_idx;
    logic             w_in_xfer;
    logic [N-1:0]     w_in_ready;

    // k-th candidate of the scan: k-1 for fixed priority, ptr+k modulo N for round-robin
    function automatic logic [SELW-1:0] scan_idx(input logic [SELW-1:0] ptr, input int k);
        int sum;
        if (MODE == 1) begin
            sum = k - 1;
        end else begin
            sum = int'(ptr) + k;
        end
        if (sum >= N) begin
            sum = sum - N;
        end else begin
            sum = sum;
        end
        return SELW'(sum);
    endfunction

    assign w_can_load = !r_out_valid || out_ready;

    // Grant: first requesting channel in scan order; independent of in_ready
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = {SELW{1'b0}};
        for (int k = 1; k <= N; k++) begin
            if (!w_gnt_any && in_valid[scan_idx(r_ptr, k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = scan_idx(r_ptr, k);
            end else begin
                w_gnt_any = w_gnt_any;
            end
        end
    end

    assign w_in_xfer = w_gnt_any && w_can_load && !reset;

    // Accept strobe: only the granted channel, only when the output stage can load
    always_comb begin
        w_in_ready = {N{1'b0}};
        if (w_in_xfer) begin
            w_in_ready[w_gnt_idx] = 1'b1;
        end else begin
            w_in_ready = {N{1'b0}};
        end
    end

    // Output register and round-robin pointer; a pending word is dropped on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
            r_out_sel   <= {SELW{1'b0}};
            r_ptr       <= SELW'(N - 1);
        end else begin
            if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[w_gnt_idx];
                r_out_sel   <= w_gnt_idx;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
            if ((MODE == 0) && w_in_xfer) begin
                r_ptr <= w_gnt_idx;
            end else begin
                r_ptr <= r_ptr;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Directed bench for bus_arb_mux: round-robin N=4, fixed-priority N=4 and
// round-robin N=3 instances share clock and reset.
module tb_bus_arb_mux;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0][15:0] a_data;
    logic [3:0]       a_valid, a_ready;
    logic [15:0]      a_odata;
    logic             a_ovalid, a_oready;
    logic [1:0]       a_osel;

    logic [3:0][15:0] f_data;
    logic [3:0]       f_valid, f_ready;
    logic [15:0]      f_odata;
    logic             f_ovalid, f_oready;
    logic [1:0]       f_osel;

    logic [2:0][15:0] t_data;
    logic [2:0]       t_valid, t_ready;
    logic [15:0]      t_odata;
    logic             t_ovalid, t_oready;
    logic [1:0]       t_osel;

    int tests  = 0;
    int failed = 0;

    bus_arb_mux #(.WIDTH(16), .N(4), .MODE(0)) u_rr (
        .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready), .out_sel(a_osel));

    bus_arb_mux #(.WIDTH(16), .N(4), .MODE(1)) u_fp (
        .clk(clk), .reset(reset), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
        .out_data(f_odata), .out_valid(f_ovalid), .out_ready(f_oready), .out_sel(f_osel));

    bus_arb_mux #(.WIDTH(16), .N(3), .MODE(0)) u_n3 (
        .clk(clk), .reset(reset), .in_data(t_data), .in_valid(t_valid), .in_ready(t_ready),
        .out_data(t_odata), .out_valid(t_ovalid), .out_ready(t_oready), .out_sel(t_osel));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] rot_data [4];
    logic [15:0] n3_data  [3];

    initial begin
        rot_data = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        n3_data  = '{16'hAAA0, 16'hAAA1, 16'hAAA2};
        reset = 1'b1;
        a_data = '0; a_valid = 4'b0000; a_oready = 1'b0;
        f_data = '0; f_valid = 4'b0000; f_oready = 1'b0;
        t_data = '0; t_valid = 3'b000;  t_oready = 1'b0;

        // Reset for two cycles; in_ready must stay low even with requests present
        cyc();
        cyc();
        chk("rst_out_valid", 64'(a_ovalid), 64'd0);
        chk("rst_out_data",  64'(a_odata),  64'd0);
        chk("rst_out_sel",   64'(a_osel),   64'd0);
        a_valid = 4'b1111; a_oready = 1'b1;
        #1;
        chk("rst_in_ready", 64'(a_ready), 64'd0);

        // Single request on channel 2
        reset = 1'b0;
        a_valid = 4'b0100;
        a_data[2] = 16'h89AB;
        #1;
        chk("single_in_ready", 64'(a_ready), 64'h4);
        cyc();
        a_valid = 4'b0000;
        chk("single_out_valid", 64'(a_ovalid), 64'd1);
        chk("single_out_data",  64'(a_odata),  64'h89AB);
        chk("single_out_sel",   64'(a_osel),   64'd2);

        // Reset pulse so the rotation starts at channel 0
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        // Round-robin rotation over four always-valid channels
        for (int i = 0; i < 4; i++) a_data[i] = rot_data[i];
        a_valid = 4'b1111;
        a_oready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rot_in_ready", 64'(a_ready), 64'(4'b0001 << (k % 4)));
            cyc();
            chk("rot_out_sel",  64'(a_osel),  64'(k % 4));
            chk("rot_out_data", 64'(a_odata), 64'(rot_data[k % 4]));
        end

        // Backpressure: output full and stalled, everything held
        a_oready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 64'(a_ready), 64'd0);
            cyc();
            chk("bp_out_valid", 64'(a_ovalid), 64'd1);
            chk("bp_out_sel",   64'(a_osel),   64'd3);
            chk("bp_out_data",  64'(a_odata),  64'hCDEF);
        end
        a_oready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(a_ready), 64'h1);
        cyc();
        chk("bp_release_sel",  64'(a_osel),  64'd0);
        chk("bp_release_data", 64'(a_odata), 64'h0123);

        // Reset while the output holds a word
        a_oready = 1'b0;
        a_valid = 4'b0110;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready_now", 64'(a_ready), 64'd0);
        cyc();
        chk("midrst_out_valid", 64'(a_ovalid), 64'd0);
        chk("midrst_out_data",  64'(a_odata),  64'd0);
        chk("midrst_in_ready",  64'(a_ready),  64'd0);
        reset = 1'b0;
        #1;
        chk("midrst_first_grant", 64'(a_ready), 64'h2);
        cyc();
        chk("midrst_out_sel",  64'(a_osel),  64'd1);
        chk("midrst_out_data2", 64'(a_odata), 64'h4567);
        a_oready = 1'b1;
        #1;
        chk("midrst_next_grant", 64'(a_ready), 64'h4);
        a_valid = 4'b0000;

        // Fixed priority: channel 1 always beats channel 3
        f_data[1] = 16'h1111;
        f_data[3] = 16'h3333;
        f_valid = 4'b1010;
        f_oready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fp_in_ready", 64'(f_ready), 64'h2);
            cyc();
            chk("fp_out_valid", 64'(f_ovalid), 64'd1);
            chk("fp_out_sel",   64'(f_osel),   64'd1);
            chk("fp_out_data",  64'(f_odata),  64'h1111);
        end
        f_valid = 4'b0000;

        // Non-power-of-two wrap with N=3
        for (int i = 0; i < 3; i++) t_data[i] = n3_data[i];
        t_valid = 3'b111;
        t_oready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("n3_in_ready", 64'(t_ready), 64'(3'b001 << (k % 3)));
            cyc();
            chk("n3_out_sel",  64'(t_osel),  64'(k % 3));
            chk("n3_out_data", 64'(t_odata), 64'(n3_data[k % 3]));
        end
        t_valid = 3'b000;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
